sim_step_sequencer: RTL and testbench

Timestep controller for the drum/heat-map column array and its pixel write-out. Issues the start pulse to every column solver, waits for all done flags with a watchdog, then reads each column's centre node through a column-select mux. It colour-quantises each node to RGB332 and writes one pixel per column into the VGA pixel memory, stalling on the display-side write window. It sits between the HPS/run controls, the column solver array and the M10K pixel memory.

---
 rtl/sim_step_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_sim_step_sequencer.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_step_sequencer.sv
// Timestep sequencer: pulses the column solvers, waits for all done flags under a watchdog,
// then colour-quantises each column's centre node and writes one RGB332 pixel per column.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for run or step_req
// START   | col_start pulse, watchdog cleared
// SETTLE  | one cycle with col_done ignored (flags may be stale)
// COMPUTE | waiting for &col_done, watchdog counting
// SEL     | drive col_sel with the current column index
// LAT     | node mux latency cycle
// QUANT   | wait for write_allow, then capture pixel and address
// WRITE   | hold write_en for WR_HOLD cycles
// NEXT    | advance column or finish the frame
// DONE    | bump step_count, pulse frame_done
module sim_step_sequencer #(
    parameter int NUM_COLS  = 32,
    parameter int COL_W     = 8,
    parameter int ADDR_W    = 8,
    parameter int ADDR_BASE = 31,
    parameter int WR_HOLD   = 3,
    parameter int TIMEOUT   = 4096
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic                run,
    input  logic                step_req,
    input  logic                write_allow,
    input  logic [NUM_COLS-1:0] col_done,
    input  logic signed [31:0]  node_in,
    output logic                col_start,
    output logic [COL_W-1:0]    col_sel,
    output logic [7:0]          write_data,
    output logic [ADDR_W-1:0]   write_addr,
    output logic                write_en,
    output logic                frame_done,
    output logic [15:0]         step_count,
    output logic                busy,
    output logic                err_timeout
);

    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

    localparam logic [COL_W-1:0]  LAST_K   = COL_W'(NUM_COLS - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(WR_HOLD - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(ADDR_BASE);

    // Node is signed 5.27 fixed point; thresholds are +/-2, 4, 6.
    localparam logic signed [31:0] TH_P6 = 32'sh30000000;
    localparam logic signed [31:0] TH_P4 = 32'sh20000000;
    localparam logic signed [31:0] TH_P2 = 32'sh10000000;
    localparam logic signed [31:0] TH_N4 = 32'shE0000000;
    localparam logic signed [31:0] TH_N6 = 32'shD0000000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_SETTLE,
        S_COMPUTE,
        S_SEL,
        S_LAT,
        S_QUANT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [COL_W-1:0]  k, k_n;
    logic [WD_W-1:0]   wd, wd_n;
    logic [HOLD_W-1:0] hold, hold_n;

    logic              col_start_n;
    logic [COL_W-1:0]  col_sel_n;
    logic [7:0]        write_data_n;
    logic [ADDR_W-1:0] write_addr_n;
    logic              write_en_n;
    logic              frame_done_n;
    logic [15:0]       step_count_n;
    logic              busy_n;
    logic              err_timeout_n;

    function automatic logic [7:0] colour(input logic signed [31:0] v);
        logic [7:0] c;
        if (v >= TH_P6)       c = 8'hE0;
        else if (v >= TH_P2 + TH_P2) c = 8'hE8;
        else if (v >= TH_P2)  c = 8'hCD;
        else if (v > 0)       c = 8'hF8;
        else if (v == 0)      c = 8'h77;
        else if (v >= TH_N4)  c = 8'h00;
        else if (v >= TH_N6)  c = 8'hE3;
        else                  c = 8'hFF;
        return c;
    endfunction

    always_comb begin
        state_n       = state;
        k_n           = k;
        wd_n          = wd;
        hold_n        = hold;
        col_sel_n     = col_sel;
        write_data_n  = write_data;
        write_addr_n  = write_addr;
        write_en_n    = 1'b0;
        frame_done_n  = 1'b0;
        step_count_n  = step_count;
        err_timeout_n = err_timeout;

        case (state)
            S_IDLE: begin
                if (run || step_req) state_n = S_START;
            end
            S_START: begin
                wd_n    = '0;
                state_n = S_SETTLE;
            end
            S_SETTLE: begin
                state_n = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (&col_done) begin
                    k_n     = '0;
                    state_n = S_SEL;
                end else if (wd == WD_LAST) begin
                    err_timeout_n = 1'b1;
                    state_n       = S_IDLE;
                end else begin
                    wd_n = wd + WD_W'(1);
                end
            end
            S_SEL: begin
                col_sel_n = k;
                state_n   = S_LAT;
            end
            S_LAT: begin
                state_n = S_QUANT;
            end
            S_QUANT: begin
                if (write_allow) begin
                    write_addr_n = BASE + ADDR_W'(k);
                    write_data_n = colour(node_in);
                    write_en_n   = 1'b1;
                    hold_n       = HOLD_MAX;
                    state_n      = S_WRITE;
                end
            end
            S_WRITE: begin
                // Hold runs to completion regardless of write_allow.
                if (hold == '0) begin
                    state_n = S_NEXT;
                end else begin
                    write_en_n = 1'b1;
                    hold_n     = hold - HOLD_W'(1);
                end
            end
            S_NEXT: begin
                if (k == LAST_K) begin
                    state_n = S_DONE;
                end else begin
                    k_n     = k + COL_W'(1);
                    state_n = S_SEL;
                end
            end
            S_DONE: begin
                step_count_n = step_count + 16'd1;
                frame_done_n = 1'b1;
                state_n      = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        col_start_n = (state_n == S_START);
        busy_n      = (state_n != S_IDLE);
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state       <= S_IDLE;
            k           <= '0;
            wd          <= '0;
            hold        <= '0;
            col_start   <= 1'b0;
            col_sel     <= '0;
            write_data  <= '0;
            write_addr  <= '0;
            write_en    <= 1'b0;
            frame_done  <= 1'b0;
            step_count  <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            k           <= k_n;
            wd          <= wd_n;
            hold        <= hold_n;
            col_start   <= col_start_n;
            col_sel     <= col_sel_n;
            write_data  <= write_data_n;
            write_addr  <= write_addr_n;
            write_en    <= write_en_n;
            frame_done  <= frame_done_n;
            step_count  <= step_count_n;
            busy        <= busy_n;
            err_timeout <= err_timeout_n;
        end
    end

endmodule

// File: tb/tb_sim_step_sequencer.sv
// Bench for sim_step_sequencer: column/node models plus a pixel scoreboard checked on each write.
module tb_sim_step_sequencer;

    localparam int NCOL = 32;

    logic              clk_50 = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic              step_req = 1'b0;
    logic              write_allow = 1'b1;
    logic [NCOL-1:0]   col_done = '0;
    logic signed [31:0] node_in = '0;
    logic              col_start;
    logic [7:0]        col_sel;
    logic [7:0]        write_data;
    logic [7:0]        write_addr;
    logic              write_en;
    logic              frame_done;
    logic [15:0]       step_count;
    logic              busy;
    logic              err_timeout;

    sim_step_sequencer #(.TIMEOUT(64)) dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .run        (run),
        .step_req   (step_req),
        .write_allow(write_allow),
        .col_done   (col_done),
        .node_in    (node_in),
        .col_start  (col_start),
        .col_sel    (col_sel),
        .write_data (write_data),
        .write_addr (write_addr),
        .write_en   (write_en),
        .frame_done (frame_done),
        .step_count (step_count),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk_50 = ~clk_50;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cs_cnt = 0;
    int fd_cnt = 0;
    int wr_cnt = 0;
    int exp_steps = 0;

    logic signed [31:0] node_tab [NCOL];
    logic signed [31:0] node_pipe = '0;
    logic [NCOL-1:0]    stuck_mask = '0;
    int                 dcnt = 0;

    // Column array: flags drop on col_start and rise three cycles later; node mux has one cycle latency.
    always @(negedge clk_50) begin
        node_in   = node_pipe;
        node_pipe = node_tab[col_sel[4:0]];
        if (col_start) begin
            col_done = '0;
            dcnt     = 3;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) col_done = ~stuck_mask;
        end
    end

    logic       prev_we = 1'b0;
    logic       prev_cs = 1'b0;
    int         wr_len = 0;
    logic [7:0] h_addr, h_data;
    exp_t       e_mon;

    always @(negedge clk_50) begin
        if (reset) begin
            prev_we = 1'b0;
            prev_cs = 1'b0;
            wr_len  = 0;
        end else begin
            if (col_start) begin
                cs_cnt++;
                total++;
                if (prev_cs) begin
                    bad++;
                    $display("FAIL col_start_width got=2+ cycles want=1");
                end
            end
            if (frame_done) fd_cnt++;
            if (write_en && !prev_we) begin
                wr_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write addr=%0d data=%h", write_addr, write_data);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (write_addr !== e_mon.addr || write_data !== e_mon.data) begin
                        bad++;
                        $display("FAIL pixel got addr=%0d data=%h want addr=%0d data=%h",
                                 write_addr, write_data, e_mon.addr, e_mon.data);
                    end
                end
                h_addr = write_addr;
                h_data = write_data;
                wr_len = 1;
            end else if (write_en) begin
                wr_len++;
                total++;
                if (write_addr !== h_addr || write_data !== h_data) begin
                    bad++;
                    $display("FAIL hold_stable got addr=%0d data=%h want addr=%0d data=%h",
                             write_addr, write_data, h_addr, h_data);
                end
            end else if (prev_we) begin
                total++;
                if (wr_len != 3) begin
                    bad++;
                    $display("FAIL write_width got=%0d want=3", wr_len);
                end
            end
            prev_we = write_en;
            prev_cs = col_start;
        end
    end

    function automatic logic [7:0] ref_colour(input logic signed [31:0] v);
        real r;
        r = $itor(v) / 134217728.0;
        if (r >= 6.0)       return 8'hE0;
        else if (r >= 4.0)  return 8'hE8;
        else if (r >= 2.0)  return 8'hCD;
        else if (r > 0.0)   return 8'hF8;
        else if (r == 0.0)  return 8'h77;
        else if (r >= -4.0) return 8'h00;
        else if (r >= -6.0) return 8'hE3;
        else                return 8'hFF;
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int c = 0; c < NCOL; c++) begin
            e.addr = 8'(31 + c);
            e.data = ref_colour(node_tab[c]);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_sig(input int which, input int limit, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk_50);
            cycles++;
            case (which)
                0:       ok = (col_start === 1'b1);
                1:       ok = (frame_done === 1'b1);
                2:       ok = (err_timeout === 1'b1);
                default: ok = (write_en === 1'b1 && col_sel == 8'd10);
            endcase
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_50);
        total++;
        if ({col_start, col_sel, write_data, write_addr, write_en, frame_done,
             step_count, busy, err_timeout} !== 45'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {col_start, col_sel, write_data,
                     write_addr, write_en, frame_done, step_count, busy, err_timeout});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_50);
        total++;
        if (busy !== 1'b0 || col_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got busy=%b col_start=%b want 0 0", busy, col_start);
        end
    endtask

    task automatic test_run_frame();
        int cyc;
        bit ok;
        for (int c = 0; c < NCOL; c++) node_tab[c] = $signed($urandom());
        push_frame();
        run = 1'b1;
        wait_sig(0, 10, cyc, ok);
        total++;
        if (!ok || cyc != 1) begin
            bad++;
            $display("FAIL start_latency got=%0d ok=%b want=1", cyc, ok);
        end
        wait_sig(1, 400, cyc, ok);
        total++;
        if (!ok || cyc != 229) begin
            bad++;
            $display("FAIL frame_latency got=%0d ok=%b want=229", cyc, ok);
        end
        exp_steps++;
        push_frame();
        total++;
        if (step_count !== 16'(exp_steps)) begin
            bad++;
            $display("FAIL step_count_run1 got=%0d want=%0d", step_count, exp_steps);
        end
        #1;
        total++;
        if (cs_cnt != 1 || fd_cnt != 1) begin
            bad++;
            $display("FAIL pulse_count_run1 got cs=%0d fd=%0d want 1 1", cs_cnt, fd_cnt);
        end
        wait_sig(0, 5, cyc, ok);
        total++;
        if (!ok || cyc != 1) begin
            bad++;
            $display("FAIL restart_latency got=%0d ok=%b want=1", cyc, ok);
        end
        run = 1'b0;
        wait_sig(1, 400, cyc, ok);
        exp_steps++;
        repeat (10) @(negedge clk_50);
        #1;
        total++;
        if (!ok || busy !== 1'b0 || cs_cnt != 2 || fd_cnt != 2 || step_count !== 16'(exp_steps)) begin
            bad++;
            $display("FAIL run_drop got ok=%b busy=%b cs=%0d fd=%0d steps=%0d want 1 0 2 2 %0d",
                     ok, busy, cs_cnt, fd_cnt, step_count, exp_steps);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL run_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_colour_map();
        logic signed [31:0] nodes [8];
        logic [7:0]         want [8];
        exp_t e;
        int cyc;
        bit ok;
        nodes = '{32'sh30000000, 32'sh20000000, 32'sh10000000, 32'sh00000001,
                  32'sh00000000, 32'shE0000000, 32'shD0000000, 32'shCFFFFFFF};
        want  = '{8'hE0, 8'hE8, 8'hCD, 8'hF8, 8'h77, 8'h00, 8'hE3, 8'hFF};
        for (int c = 0; c < NCOL; c++) node_tab[c] = (c < 8) ? nodes[c] : $signed($urandom());
        for (int c = 0; c < NCOL; c++) begin
            e.addr = 8'(31 + c);
            e.data = (c < 8) ? want[c] : ref_colour(node_tab[c]);
            exp_q.push_back(e);
        end
        step_req = 1'b1;
        @(negedge clk_50);
        step_req = 1'b0;
        wait_sig(1, 400, cyc, ok);
        exp_steps++;
        total++;
        if (!ok || step_count !== 16'(exp_steps)) begin
            bad++;
            $display("FAIL colour_frame got ok=%b steps=%0d want 1 %0d", ok, step_count, exp_steps);
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL colour_leftover got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_write_stall();
        int cyc;
        bit ok, found, seen_we, still_busy;
        for (int c = 0; c < NCOL; c++) node_tab[c] = $signed($urandom());
        node_tab[5] = 32'shE8000000;
        push_frame();
        node_tab[5] = 32'sh28000000;
        write_allow = 1'b1;
        step_req = 1'b1;
        @(negedge clk_50);
        step_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk_50);
            if (col_sel == 8'd5) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL stall_reach got col_sel=%0d want=5", col_sel);
        end
        write_allow = 1'b0;
        seen_we = 1'b0;
        still_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50);
            if (write_en !== 1'b0) seen_we = 1'b1;
            if (busy !== 1'b1) still_busy = 1'b0;
            if (i == 3) node_tab[5] = 32'shE8000000;
        end
        total++;
        if (seen_we || !still_busy) begin
            bad++;
            $display("FAIL stall_hold got write_seen=%b busy=%b want 0 1", seen_we, still_busy);
        end
        write_allow = 1'b1;
        @(negedge clk_50);
        total++;
        if (write_en !== 1'b1 || write_addr !== 8'd36) begin
            bad++;
            $display("FAIL stall_release got we=%b addr=%0d want 1 36", write_en, write_addr);
        end
        write_allow = 1'b0;
        repeat (2) @(negedge clk_50);
        total++;
        if (write_en !== 1'b1) begin
            bad++;
            $display("FAIL hold_not_aborted got we=%b want 1", write_en);
        end
        write_allow = 1'b1;
        wait_sig(1, 400, cyc, ok);
        exp_steps++;
        #1;
        total++;
        if (!ok || step_count !== 16'(exp_steps) || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stall_frame got ok=%b steps=%0d left=%0d want 1 %0d 0",
                     ok, step_count, exp_q.size(), exp_steps);
        end
    endtask

    task automatic test_step_req();
        int cyc, c0, f0;
        bit ok;
        for (int c = 0; c < NCOL; c++) node_tab[c] = $signed($urandom());
        push_frame();
        c0 = cs_cnt;
        f0 = fd_cnt;
        step_req = 1'b1;
        @(negedge clk_50);
        step_req = 1'b0;
        repeat (5) @(negedge clk_50);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL step_busy got=%b want=1", busy);
        end
        step_req = 1'b1;
        @(negedge clk_50);
        step_req = 1'b0;
        wait_sig(1, 400, cyc, ok);
        exp_steps++;
        repeat (20) @(negedge clk_50);
        #1;
        total++;
        if (!ok || cs_cnt - c0 != 1 || fd_cnt - f0 != 1 || busy !== 1'b0 ||
            step_count !== 16'(exp_steps)) begin
            bad++;
            $display("FAIL single_step got ok=%b starts=%0d frames=%0d busy=%b steps=%0d want 1 1 1 0 %0d",
                     ok, cs_cnt - c0, fd_cnt - f0, busy, step_count, exp_steps);
        end
        push_frame();
        c0 = cs_cnt;
        run = 1'b1;
        step_req = 1'b1;
        @(negedge clk_50);
        run = 1'b0;
        step_req = 1'b0;
        wait_sig(1, 400, cyc, ok);
        exp_steps++;
        repeat (20) @(negedge clk_50);
        #1;
        total++;
        if (!ok || cs_cnt - c0 != 1 || step_count !== 16'(exp_steps) || exp_q.size() != 0) begin
            bad++;
            $display("FAIL run_and_step got ok=%b starts=%0d steps=%0d left=%0d want 1 1 %0d 0",
                     ok, cs_cnt - c0, step_count, exp_q.size(), exp_steps);
        end
    endtask

    task automatic test_timeout();
        int cyc, w0;
        bit ok;
        stuck_mask = '0;
        stuck_mask[17] = 1'b1;
        w0 = wr_cnt;
        step_req = 1'b1;
        wait_sig(0, 5, cyc, ok);
        step_req = 1'b0;
        total++;
        if (!ok || cyc != 1) begin
            bad++;
            $display("FAIL timeout_start got=%0d ok=%b want=1", cyc, ok);
        end
        wait_sig(2, 200, cyc, ok);
        total++;
        if (!ok || cyc != 66) begin
            bad++;
            $display("FAIL timeout_latency got=%0d ok=%b want=66", cyc, ok);
        end
        total++;
        if (busy !== 1'b0 || step_count !== 16'(exp_steps)) begin
            bad++;
            $display("FAIL timeout_idle got busy=%b steps=%0d want 0 %0d", busy, step_count, exp_steps);
        end
        repeat (5) @(negedge clk_50);
        #1;
        total++;
        if (wr_cnt != w0 || err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_nowrite got writes=%0d err=%b want 0 1", wr_cnt - w0, err_timeout);
        end
        stuck_mask = '0;
        push_frame();
        step_req = 1'b1;
        @(negedge clk_50);
        step_req = 1'b0;
        wait_sig(1, 400, cyc, ok);
        exp_steps++;
        #1;
        total++;
        if (!ok || step_count !== 16'(exp_steps) || err_timeout !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL timeout_recover got ok=%b steps=%0d err=%b left=%0d want 1 %0d 1 0",
                     ok, step_count, err_timeout, exp_q.size(), exp_steps);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        bit ok, seen;
        for (int c = 0; c < NCOL; c++) node_tab[c] = $signed($urandom());
        push_frame();
        @(negedge clk_50);
        step_req = 1'b1;
        @(negedge clk_50);
        step_req = 1'b0;
        wait_sig(3, 400, cyc, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL reach_col10 got col_sel=%0d we=%b want 10 1", col_sel, write_en);
        end
        reset = 1'b1;
        @(negedge clk_50);
        total++;
        if ({col_start, col_sel, write_data, write_addr, write_en, frame_done,
             step_count, busy, err_timeout} !== 45'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h want=0", {col_start, col_sel, write_data,
                     write_addr, write_en, frame_done, step_count, busy, err_timeout});
        end
        @(negedge clk_50);
        reset = 1'b0;
        exp_q.delete();
        exp_steps = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50);
            if (write_en !== 1'b0 || col_start !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen || step_count !== 16'd0) begin
            bad++;
            $display("FAIL midreset_quiet got activity=%b steps=%0d want 0 0", seen, step_count);
        end
    endtask

    initial begin
        for (int c = 0; c < NCOL; c++) node_tab[c] = '0;
        @(negedge clk_50);
        test_reset();
        test_run_frame();
        test_colour_map();
        test_write_stall();
        test_step_req();
        test_timeout();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=hang want=finish");
        $fatal(1);
    end

endmodule
